// File: rtl/line_window_pkg.sv
// line_window_pkg: shared types and helpers for the line window buffer.
// State encoding, pointer sizing and line length clamping.
package line_window_pkg;

  localparam int DEF_MAX_LINE_LENGTH = 512;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int PTR_WIDTH = clog2(DEF_MAX_LINE_LENGTH);

  // Zero or oversized lengths fall back to the full RAM depth.
  function automatic logic [31:0] clamp_len(
    input logic [31:0] len,
    input logic [31:0] max_len
  );
    if (len == 32'd0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// line_window_buffer_if: pixel stream in, pixel column out.
// master drives the stream, slave is the buffer.
interface line_window_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LINES  = 3
);

  logic                            enable;
  logic                            sof;
  logic                            valid_in;
  logic [DATA_WIDTH-1:0]           data_in;
  logic [31:0]                     length;
  logic [NUM_LINES*DATA_WIDTH-1:0] data_out;
  logic                            valid_out;
  logic [31:0]                     col_index;
  logic [31:0]                     line_index;
  logic                            primed;

  modport master (
    output enable, sof, valid_in, data_in, length,
    input  data_out, valid_out, col_index, line_index, primed
  );

  modport slave (
    input  enable, sof, valid_in, data_in, length,
    output data_out, valid_out, col_index, line_index, primed
  );

endinterface

// File: rtl/line_ram.sv
// line_ram: one image line of storage, read-before-write.
// The pre-write word feeds the next line and the column register.
module line_ram
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_LINE_LENGTH = 512
) (
  input  logic                                clock,
  input  logic                                i_en,
  input  logic [clog2(MAX_LINE_LENGTH)-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]               i_wdata,
  output logic [DATA_WIDTH-1:0]               o_old
);

  logic [DATA_WIDTH-1:0] r_mem [MAX_LINE_LENGTH];

  assign o_old = r_mem[i_addr];

  // Store the new pixel; the old word has already been handed on.
  always_ff @(posedge clock) begin
    if (i_en) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: NUM_LINES tall pixel column over a raster stream.
// Define LINE_WINDOW_BORDER_REPLICATE_EN to output from the first line.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_LINE_LENGTH = 512,
  parameter int NUM_LINES       = 3
) (
  input logic                 clock,
  input logic                 reset,
  line_window_buffer_if.slave bus
);

  localparam int          AW        = clog2(MAX_LINE_LENGTH);
  localparam int          NR        = NUM_LINES - 1;
  localparam logic [31:0] MAXL      = 32'(MAX_LINE_LENGTH);
  localparam logic [31:0] LAST_FILL = 32'(NUM_LINES - 2);

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_len;
  logic [AW-1:0] r_ptr;
  logic [31:0] r_line;

  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] r_data;
  logic        r_valid;
  logic [31:0] r_col_idx;
  logic [31:0] r_line_idx;

  logic        w_acc;
  logic        w_sof;
  logic        w_run;
  logic        w_proc;
  logic        w_last;
  logic        w_vld;
  logic [31:0] w_len;
  logic [31:0] w_len_m1;
  logic [AW-1:0] w_ptr;
  logic [31:0] w_line;
  logic [31:0] w_line_inc;

  logic [NR-1:0][DATA_WIDTH-1:0]        w_wdata;
  logic [NR-1:0][DATA_WIDTH-1:0]        w_old;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] w_win;

  assign w_acc  = bus.enable & bus.valid_in;
  assign w_sof  = w_acc & bus.sof;
  assign w_run  = w_acc & ~bus.sof & (r_state != IDLE);
  assign w_proc = w_sof | w_run;

  // A sof pixel is column 0 of line 0 under the newly latched length.
  assign w_len    = w_sof ? clamp_len(bus.length, MAXL) : r_len;
  assign w_len_m1 = w_len - 32'd1;
  assign w_ptr    = w_sof ? '0 : r_ptr;
  assign w_line   = w_sof ? '0 : r_line;
  assign w_last   = (32'(w_ptr) == w_len_m1);
  assign w_line_inc = (w_line == '1) ? w_line : w_line + 32'd1;

  // Each line RAM passes its displaced pixel down to the next one.
  always_comb begin
    w_wdata = '0;
    w_wdata[0] = bus.data_in;
    for (int k = 1; k < NR; k++) w_wdata[k] = w_old[k-1];
  end

  for (genvar g = 0; g < NR; g++) begin : g_line
    line_ram #(
      .DATA_WIDTH      (DATA_WIDTH),
      .MAX_LINE_LENGTH (MAX_LINE_LENGTH)
    ) u_line (
      .clock   (clock),
      .i_en    (w_proc),
      .i_addr  (w_ptr),
      .i_wdata (w_wdata[g]),
      .o_old   (w_old[g])
    );
  end

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
  // Lines not yet written this frame repeat the oldest written one.
  always_comb begin
    w_win = '0;
    w_win[0] = bus.data_in;
    for (int k = 1; k < NUM_LINES; k++)
      w_win[k] = (w_line >= 32'(k)) ? w_old[k-1] : w_win[k-1];
  end
  assign w_vld = w_proc;
`else
  // Column straight from the taps; only used once STREAM is reached.
  always_comb begin
    w_win = '0;
    w_win[0] = bus.data_in;
    for (int k = 1; k < NUM_LINES; k++) w_win[k] = w_old[k-1];
  end
  assign w_vld = w_run & (r_state == STREAM);
`endif

  // Advance the write pointer and line counter per processed pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len  <= MAXL;
      r_ptr  <= '0;
      r_line <= '0;
    end else if (w_proc) begin
      r_len  <= w_len;
      r_ptr  <= w_last ? '0 : w_ptr + AW'(1);
      r_line <= w_last ? w_line_inc : w_line;
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // sof restarts filling; the last fill line ending starts streaming.
  always_comb begin
    w_state_nx = r_state;
    if (w_sof) w_state_nx = FILL;
    if (w_proc && w_state_nx == FILL && w_last && w_line == LAST_FILL)
      w_state_nx = STREAM;
  end

  // Column output register, frozen while enable is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_col_idx  <= '0;
      r_line_idx <= '0;
    end else if (bus.enable) begin
      r_valid <= w_vld;
      if (w_proc) begin
        r_data     <= w_win;
        r_col_idx  <= 32'(w_ptr);
        r_line_idx <= w_line;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.valid_out  = r_valid;
  assign bus.col_index  = r_col_idx;
  assign bus.line_index = r_line_idx;
  assign bus.primed     = (r_state == STREAM);

endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: random and directed streams against a
// frame-history model of the line window buffer.
module tb_line_window_buffer;

  localparam int DW   = 8;
  localparam int MAXL = 512;
  localparam int NL   = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  line_window_buffer_if #(.DATA_WIDTH(DW), .NUM_LINES(NL)) bus ();

  line_window_buffer #(
    .DATA_WIDTH      (DW),
    .MAX_LINE_LENGTH (MAXL),
    .NUM_LINES       (NL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vec = 0;
  int bad = 0;

  logic [DW-1:0] frame[$];
  bit            active;
  int            L;
  bit            e_valid;
  bit            e_primed;
  logic [31:0]   e_col;
  logic [31:0]   e_line;
  logic [NL*DW-1:0] e_data;

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  function automatic int model_len(input logic [31:0] len);
    if (len == 0 || len > MAXL) return MAXL;
    return int'(len);
  endfunction

  task automatic model_reset();
    frame.delete();
    active   = 0;
    L        = MAXL;
    e_valid  = 0;
    e_primed = 0;
    e_col    = 0;
    e_line   = 0;
    e_data   = '0;
  endtask

  // One clock: drive inputs, wait past the edge, update the model.
  task automatic step(input bit e, input bit v, input bit s,
                      input logic [DW-1:0] d, input logic [31:0] len);
    int n;
    int ln;
    int kk;
    bus.enable   = e;
    bus.valid_in = v;
    bus.sof      = s;
    bus.data_in  = d;
    bus.length   = len;
    @(posedge clock);
    #1;
    if (e && v) begin
      if (s) begin
        frame.delete();
        active = 1;
        L = model_len(len);
      end
      if (active) begin
        frame.push_back(d);
        n  = frame.size() - 1;
        ln = n / L;
        e_col   = n % L;
        e_line  = ln;
        e_valid = REPL || (ln >= NL - 1);
        for (int k = 0; k < NL; k++) begin
          kk = (k <= ln) ? k : ln;
          e_data[k*DW +: DW] = frame[n - kk*L];
        end
        e_primed = frame.size() >= (NL - 1) * L;
      end else begin
        e_valid = 0;
      end
    end else if (e) begin
      e_valid = 0;
    end
  endtask

  task automatic test_reset();
    bus.enable = 0; bus.valid_in = 0; bus.sof = 0;
    bus.data_in = 0; bus.length = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vec++;
    if ({bus.valid_out, bus.primed, bus.col_index,
         bus.line_index, bus.data_out} !== '0) begin
      bad++;
      $display("FAIL reset: got v=%0b p=%0b c=%0d l=%0d d=%h exp all 0",
               bus.valid_out, bus.primed, bus.col_index,
               bus.line_index, bus.data_out);
    end
    #2 reset = 1;
    // pixels before any sof are dropped
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, DW'($urandom), 4);
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line}) begin
        bad++;
        $display("FAIL idle_drop: got v=%0b c=%0d l=%0d exp v=%0b c=%0d l=%0d",
                 bus.valid_out, bus.col_index, bus.line_index,
                 e_valid, e_col, e_line);
      end
    end
  endtask

  task automatic test_basic();
    for (int p = 1; p <= 12; p++) begin
      step(1, 1, p == 1, DW'(p), 4);
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line} ||
          (e_valid && bus.data_out !== e_data)) begin
        bad++;
        $display("FAIL basic p%0d: got v=%0b p=%0b c=%0d l=%0d d=%h exp v=%0b p=%0b c=%0d l=%0d d=%h",
                 p, bus.valid_out, bus.primed, bus.col_index,
                 bus.line_index, bus.data_out, e_valid, e_primed,
                 e_col, e_line, e_data);
      end
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
      if (p == 1 || p == 5 || p == 9) begin
        vec++;
        if (bus.data_out !== (p == 1 ? 24'h010101 :
                              p == 5 ? 24'h010105 : 24'h010509)) begin
          bad++;
          $display("FAIL border p%0d: got %h", p, bus.data_out);
        end
      end
`else
      if (p == 9) begin
        vec++;
        if ({bus.valid_out, bus.col_index, bus.line_index,
             bus.data_out} !== {1'b1, 32'd0, 32'd2, 24'h010509}) begin
          bad++;
          $display("FAIL first_valid: got v=%0b c=%0d l=%0d d=%h exp 1 0 2 010509",
                   bus.valid_out, bus.col_index, bus.line_index,
                   bus.data_out);
        end
      end
`endif
    end
  endtask

  task automatic test_freeze();
    for (int p = 1; p <= 15; p++) begin
      if (p >= 11 && p <= 13)
        step(0, 1'($urandom), 1'($urandom), DW'($urandom), 7);
      else
        step(1, 1, p == 1, DW'(p > 13 ? p - 3 : p), 4);
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line} ||
          (e_valid && bus.data_out !== e_data)) begin
        bad++;
        $display("FAIL freeze s%0d: got v=%0b c=%0d l=%0d d=%h exp v=%0b c=%0d l=%0d d=%h",
                 p, bus.valid_out, bus.col_index, bus.line_index,
                 bus.data_out, e_valid, e_col, e_line, e_data);
      end
      if (p == 13) begin
        vec++;
        if ({bus.valid_out, bus.data_out} !== {1'b1, 24'h02060a}) begin
          bad++;
          $display("FAIL freeze_hold: got v=%0b d=%h exp 1 02060a",
                   bus.valid_out, bus.data_out);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] lens [2];
    lens[0] = 0;
    lens[1] = 1000;
    for (int t = 0; t < 2; t++) begin
      for (int p = 1; p <= 1030; p++) begin
        step(1, 1, p == 1, DW'($urandom), lens[t]);
        vec++;
        if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
            !== {e_valid, e_primed, e_col, e_line} ||
            (e_valid && bus.data_out !== e_data)) begin
          bad++;
          $display("FAIL clamp len%0d p%0d: got v=%0b c=%0d l=%0d d=%h exp v=%0b c=%0d l=%0d d=%h",
                   lens[t], p, bus.valid_out, bus.col_index,
                   bus.line_index, bus.data_out, e_valid, e_col,
                   e_line, e_data);
        end
        if (p == 513) begin
          vec++;
          if ({bus.col_index, bus.line_index} !== {32'd0, 32'd1}) begin
            bad++;
            $display("FAIL wrap513: got c=%0d l=%0d exp 0 1",
                     bus.col_index, bus.line_index);
          end
        end
      end
    end
  endtask

  task automatic test_midline_sof();
    for (int p = 1; p <= 30; p++) begin
      step(1, 1, p == 1 || p == 15, DW'($urandom), 4);
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line} ||
          (e_valid && bus.data_out !== e_data)) begin
        bad++;
        $display("FAIL midline p%0d: got v=%0b p=%0b c=%0d l=%0d d=%h exp v=%0b p=%0b c=%0d l=%0d d=%h",
                 p, bus.valid_out, bus.primed, bus.col_index,
                 bus.line_index, bus.data_out, e_valid, e_primed,
                 e_col, e_line, e_data);
      end
      if (p == 15) begin
        vec++;
        if ({bus.primed, bus.col_index, bus.line_index}
            !== {1'b0, 32'd0, 32'd0}) begin
          bad++;
          $display("FAIL midline_restart: got p=%0b c=%0d l=%0d exp 0 0 0",
                   bus.primed, bus.col_index, bus.line_index);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int p = 1; p <= 700; p++)
      step(1, 1, p == 1, DW'($urandom), 4);
    #2 reset = 0;
    model_reset();
    #1;
    vec++;
    if ({bus.valid_out, bus.primed, bus.col_index,
         bus.line_index, bus.data_out} !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%0b p=%0b c=%0d l=%0d d=%h exp all 0",
               bus.valid_out, bus.primed, bus.col_index,
               bus.line_index, bus.data_out);
    end
    @(posedge clock);
    #3 reset = 1;
    for (int p = 1; p <= 16; p++) begin
      step(1, 1, p == 4, DW'($urandom), 4);
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line} ||
          (e_valid && bus.data_out !== e_data)) begin
        bad++;
        $display("FAIL post_reset p%0d: got v=%0b p=%0b c=%0d l=%0d exp v=%0b p=%0b c=%0d l=%0d",
                 p, bus.valid_out, bus.primed, bus.col_index,
                 bus.line_index, e_valid, e_primed, e_col, e_line);
      end
    end
  endtask

  task automatic test_random();
    bit e, v, s;
    for (int c = 0; c < 800; c++) begin
      e = ($urandom_range(0, 99) < 85);
      v = ($urandom_range(0, 99) < 75);
      s = (c == 0) || ($urandom_range(0, 99) < 2);
      step(e, v, s, DW'($urandom), 32'($urandom_range(1, 8)));
      vec++;
      if ({bus.valid_out, bus.primed, bus.col_index, bus.line_index}
          !== {e_valid, e_primed, e_col, e_line} ||
          (e_valid && bus.data_out !== e_data)) begin
        bad++;
        $display("FAIL random c%0d: got v=%0b p=%0b c=%0d l=%0d d=%h exp v=%0b p=%0b c=%0d l=%0d d=%h",
                 c, bus.valid_out, bus.primed, bus.col_index,
                 bus.line_index, bus.data_out, e_valid, e_primed,
                 e_col, e_line, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_freeze();
    test_clamp();
    test_midline_sof();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised successor to the single scanline shift buffer.
- Stores NUM_LINES-1 previous image lines in circular RAM and presents a vertical column of NUM_LINES pixels (current plus delayed lines) each accepted cycle.
- Sits between the pixel input stream and the 2-D convolution filter core; runtime line length; frame-start aware.

Parameters:
DATA_WIDTH, 8, bits per pixel
MAX_LINE_LENGTH, 512, maximum pixels per line (RAM depth)
NUM_LINES, 3, column taps output (window height, >=2)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous active-low reset
enable  input  1  global advance; low freezes all state and outputs
sof  input  1  start of frame, qualified by valid_in; marks first pixel of frame
valid_in  input  1  data_in valid this cycle
data_in  input  DATA_WIDTH  incoming pixel
length  input  32  active line length, sampled only on accepted sof
data_out  output  NUM_LINES*DATA_WIDTH  column; slice 0 = current pixel, slice k = pixel k lines earlier
valid_out  output  1  data_out valid
col_index  output  32  column of data_out pixel
line_index  output  32  line of data_out pixel within frame
primed  output  1  NUM_LINES-1 full lines buffered

Behaviour:
- Reset (reset low, async): data_out=0, valid_out=0, col_index=0, line_index=0, primed=0, state IDLE, pointers 0. RAM contents undefined, never read before written.
- Accept = enable && valid_in. Nothing changes unless enable high.
- Length latch: on accepted sof, len_q <= length; length 0 or > MAX_LINE_LENGTH clamps to MAX_LINE_LENGTH.
- States: IDLE -> FILL on accepted sof; FILL -> STREAM when line counter reaches NUM_LINES-1 at end of line; STREAM persists until next sof; accepted sof in any state restarts FILL (mid-line abort; partial line discarded, counters zeroed, the sof pixel is column 0 line 0).
- Pixels accepted in IDLE (no sof yet) are dropped.
- Write pointer wraps len_q-1 -> 0; line counter increments on wrap, saturates at 2^32-1.
- Each RAM line read-before-write at same address: old value shifts to next line RAM (cascade), new pixel written.
- Latency: one cycle from accept to data_out/valid_out; col_index/line_index aligned with data_out.
- valid_out = 1 for one cycle per accepted pixel in STREAM; 0 in IDLE/FILL (see optional feature); held at last value while enable low.
- primed = 1 in STREAM, else 0.
- length changes without sof ignored.

Optional Feature:
- Macro LINE_WINDOW_BORDER_REPLICATE_EN.
- Defined: valid_out asserted from first accepted pixel of FILL; slices referring to lines not yet written replicate the oldest valid line (line 0 replicates data_in into all slices). primed unchanged.
- Undefined: valid_out only in STREAM as above.

Decomposition:
- Package line_window_pkg: state enum (IDLE, FILL, STREAM), function clog2, PTR_WIDTH = clog2(MAX_LINE_LENGTH), length clamp function.
- Sub-module line_ram: one line of storage, DATA_WIDTH x MAX_LINE_LENGTH, single write/read address, registered read-before-write, enable input; NUM_LINES-1 instances cascaded.

Test Plan:
- Reset mid-frame after 700 pixels, NUM_LINES=3, length=4 -> all outputs 0 immediately, next accepted sof restarts FILL.
- length=4, sof then pixels 1..12 continuous -> valid_out first high one cycle after pixel 9; data_out slices {9,5,1}, col_index 0, line_index 2; pixel 12 gives {12,8,4}.
- Same stream with enable low 3 cycles after pixel 10 -> outputs frozen, pixel 10 column {10,6,2} held, no pixel lost.
- length=0 and length=1000 with MAX 512 -> wrap occurs after 512 pixels; line_index increments at pixel 513.
- Mid-line sof at column 2 of line 3 -> primed drops, line_index 0, no valid_out until 2 further full lines (macro undefined).
- LINE_WINDOW_BORDER_REPLICATE_EN defined, length=4 -> pixel 1 yields {1,1,1}; pixel 5 yields {5,1,1}; pixel 9 yields {9,5,1}.
